// File: rtl/uart_frame_scheduler.sv
// Sends one code per module UART in index order, waits for each echo with retry/timeout, then fires shoot if all acked.
// Optional build macro UART_SCHED_SKIP_IDLE_EN: modules whose code is 8'h00 are skipped entirely.
module uart_frame_scheduler #(
  parameter int NUM_MODULES = 9,
  parameter int ACK_TIMEOUT = 48000,
  parameter int MAX_RETRIES = 2,
  parameter int SHOOT_WIDTH = 48
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     frame_valid,
  output logic                     frame_ready,
  input  logic [8*NUM_MODULES-1:0] frame_data,
  output logic [7:0]               tx_data,
  output logic [NUM_MODULES-1:0]   start_tx,
  input  logic [NUM_MODULES-1:0]   tx_busy,
  input  logic [NUM_MODULES-1:0]   rx_done,
  input  logic [8*NUM_MODULES-1:0] data_received,
  input  logic [NUM_MODULES-1:0]   parity_error,
  output logic                     shoot,
  output logic                     frame_done,
  output logic                     frame_error,
  output logic [NUM_MODULES-1:0]   fail_mask
);

  localparam int IW = (NUM_MODULES > 1) ? $clog2(NUM_MODULES) : 1;
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam int RW = $clog2(MAX_RETRIES + 2);
  localparam int SW = $clog2(SHOOT_WIDTH + 1);

  typedef enum logic [2:0] {IDLE, SEND, WAIT_ACK, NEXT, SHOOT, DONE} state_t;

  state_t                   state;
  logic [8*NUM_MODULES-1:0] codes;
  logic [IW-1:0]            idx;
  logic [RW-1:0]            retry;
  logic [TW-1:0]            timer;
  logic [SW-1:0]            shoot_cnt;

  logic [7:0] cur_code;
  logic [7:0] cur_echo;
  logic       rx_live;
  logic       echo_ok;
  logic       timed_out;

  // start_tx is still high on the first WAIT_ACK cycle, which masks an rx_done coinciding with it.
  always_comb begin
    cur_code  = codes[{idx, 3'b000} +: 8];
    cur_echo  = data_received[{idx, 3'b000} +: 8];
    rx_live   = rx_done[idx] && !start_tx[idx];
    echo_ok   = !parity_error[idx] && (cur_echo == cur_code);
    timed_out = (timer == TW'(ACK_TIMEOUT - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      frame_ready <= 1'b0;
      codes       <= '0;
      idx         <= '0;
      retry       <= '0;
      timer       <= '0;
      shoot_cnt   <= '0;
      tx_data     <= 8'h00;
      start_tx    <= '0;
      shoot       <= 1'b0;
      frame_done  <= 1'b0;
      frame_error <= 1'b0;
      fail_mask   <= '0;
    end else begin
      start_tx   <= '0;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          frame_ready <= 1'b1;
          if (frame_valid && frame_ready) begin
            codes       <= frame_data;
            fail_mask   <= '0;
            idx         <= '0;
            retry       <= '0;
            frame_ready <= 1'b0;
            state       <= SEND;
          end
        end
        SEND: begin
          tx_data <= cur_code;
`ifdef UART_SCHED_SKIP_IDLE_EN
          if (cur_code == 8'h00) state <= NEXT;
          else
`endif
          if (!tx_busy[idx]) begin
            start_tx <= NUM_MODULES'(1) << idx;
            timer    <= '0;
            state    <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          timer <= timer + 1'b1;
          // An echo landing on the expiry cycle is still judged on its content.
          if (rx_live && echo_ok) begin
            state <= NEXT;
          end else if (rx_live || timed_out) begin
            if (retry < RW'(MAX_RETRIES)) begin
              retry <= retry + 1'b1;
              state <= SEND;
            end else begin
              fail_mask[idx] <= 1'b1;
              state          <= NEXT;
            end
          end
        end
        NEXT: begin
          retry     <= '0;
          shoot_cnt <= '0;
          if (idx == IW'(NUM_MODULES - 1)) begin
            state <= SHOOT;
          end else begin
            idx   <= idx + 1'b1;
            state <= SEND;
          end
        end
        SHOOT: begin
          if (fail_mask != '0) begin
            state <= DONE;
          end else if (shoot_cnt == SW'(SHOOT_WIDTH)) begin
            shoot <= 1'b0;
            state <= DONE;
          end else begin
            shoot     <= 1'b1;
            shoot_cnt <= shoot_cnt + 1'b1;
          end
        end
        DONE: begin
          frame_done  <= 1'b1;
          frame_error <= |fail_mask;
          frame_ready <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_frame_scheduler.sv
// Bench for uart_frame_scheduler: echo responder plus frame-level reference model of attempts, fail mask and shoot.
module tb_uart_frame_scheduler;

  localparam int N  = 9;
  localparam int T  = 200;
  localparam int R  = 2;
  localparam int SW = 48;
  localparam int K_ACK = 0, K_PAR = 1, K_DAT = 2, K_SIL = 3;

  logic           clk = 1'b0;
  logic           reset;
  logic           frame_valid;
  logic           frame_ready;
  logic [8*N-1:0] frame_data;
  logic [7:0]     tx_data;
  logic [N-1:0]   start_tx;
  logic [N-1:0]   tx_busy;
  logic [N-1:0]   rx_done;
  logic [8*N-1:0] data_received;
  logic [N-1:0]   parity_error;
  logic           shoot;
  logic           frame_done;
  logic           frame_error;
  logic [N-1:0]   fail_mask;

  uart_frame_scheduler #(.NUM_MODULES(N), .ACK_TIMEOUT(T), .MAX_RETRIES(R), .SHOOT_WIDTH(SW)) dut (
    .clk(clk), .reset(reset), .frame_valid(frame_valid), .frame_ready(frame_ready),
    .frame_data(frame_data), .tx_data(tx_data), .start_tx(start_tx), .tx_busy(tx_busy),
    .rx_done(rx_done), .data_received(data_received), .parity_error(parity_error),
    .shoot(shoot), .frame_done(frame_done), .frame_error(frame_error), .fail_mask(fail_mask)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Per-frame scenario: code per module and, per attempt, how the module answers and after how many cycles.
  logic [7:0] codes [N];
  int         kind  [N][R+1];
  int         dly   [N][R+1];
  int         gen = 0;
  bit         noise_en = 1'b0;

  int         obs_mod[$];
  int         obs_cyc[$];
  int         exp_mod[$];
  logic [N-1:0] exp_mask;
  int         shoot_cycles, onehot_err, txdata_err;
  bit         done_seen, ready_fell, fall_gap_ok;
  logic       obs_error;
  logic [N-1:0] obs_mask;

  // Module-side responder: echoes after the planned delay, plus stray rx_done on modules not being served.
  initial begin : responder
    int pend, pmod, pkind, cur, lastgen, a, j;
    int att[N];
    bit drove;
    pend = 0; pmod = 0; pkind = 0; cur = 0; lastgen = 0;
    foreach (att[k]) att[k] = 0;
    rx_done = '0; parity_error = '0; data_received = '0;
    forever begin
      @(negedge clk);
      rx_done = '0; parity_error = '0; drove = 1'b0;
      if (gen != lastgen) begin
        lastgen = gen; pend = 0;
        foreach (att[k]) att[k] = 0;
      end
      if (reset) begin
        pend = 0;
      end else begin
        if (start_tx !== '0) begin
          for (int i = 0; i < N; i++) if (start_tx[i] === 1'b1) cur = i;
          a = (att[cur] > R) ? R : att[cur];
          att[cur]++;
          pend = 0;
          if (kind[cur][a] != K_SIL) begin
            pmod = cur; pkind = kind[cur][a]; pend = dly[cur][a] + 1;
          end
        end
        if (pend > 0) begin
          pend--;
          if (pend == 0) begin
            drove = 1'b1;
            rx_done[pmod] = 1'b1;
            data_received[pmod*8 +: 8] = (pkind == K_DAT) ? (codes[pmod] ^ 8'h5A) : codes[pmod];
            parity_error[pmod] = (pkind == K_PAR);
          end
        end
        if (!drove && noise_en && $urandom_range(0, 7) == 0) begin
          j = $urandom_range(0, N - 1);
          if (j != cur) begin
            rx_done[j] = 1'b1;
            data_received[j*8 +: 8] = 8'($urandom);
            parity_error[j] = 1'($urandom_range(0, 1));
          end
        end
      end
    end
  end

  // Reference model: each module gets attempts until a timely clean echo or retries run out.
  task automatic build_expect();
    int n;
    bit ok;
    exp_mod.delete();
    exp_mask = '0;
    for (int i = 0; i < N; i++) begin
`ifdef UART_SCHED_SKIP_IDLE_EN
      if (codes[i] == 8'h00) continue;
`endif
      n = 0; ok = 1'b0;
      for (int a = 0; a <= R; a++) begin
        n++;
        if (kind[i][a] == K_ACK && dly[i][a] >= 1 && dly[i][a] <= T - 1) begin
          ok = 1'b1;
          break;
        end
      end
      repeat (n) exp_mod.push_back(i);
      if (!ok) exp_mask[i] = 1'b1;
    end
  endtask

  task automatic plan_all_ack(input int d);
    for (int i = 0; i < N; i++)
      for (int a = 0; a <= R; a++) begin kind[i][a] = K_ACK; dly[i][a] = d; end
  endtask

  task automatic seq_codes();
    for (int i = 0; i < N; i++) codes[i] = 8'((i + 1) * 17);
  endtask

  function automatic bit seq_match();
    if (obs_mod.size() != exp_mod.size()) return 1'b0;
    foreach (obs_mod[k]) if (obs_mod[k] != exp_mod[k]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int count_pulses(input int m);
    int c = 0;
    foreach (obs_mod[k]) if (obs_mod[k] == m) c++;
    return c;
  endfunction

  task automatic offer_frame(input int busy_hold);
    int w = 0;
    gen++;
    while (frame_ready !== 1'b1 && w < 20) begin @(negedge clk); w++; end
    for (int i = 0; i < N; i++) frame_data[i*8 +: 8] = codes[i];
    tx_busy = '0;
    if (busy_hold > 0) tx_busy[0] = 1'b1;
    frame_valid = 1'b1;
    @(negedge clk);
    frame_valid = 1'b0;
    ready_fell = (frame_ready === 1'b0);
  endtask

  task automatic run_frame(input int busy_hold, input bit junk);
    int   cyc = 0;
    int   budget;
    logic p1 = 1'b0, p2 = 1'b0;
    budget = N * (R + 1) * (T + 4) + busy_hold + 200;
    offer_frame(busy_hold);
    obs_mod.delete(); obs_cyc.delete();
    shoot_cycles = 0; onehot_err = 0; txdata_err = 0;
    done_seen = 1'b0; fall_gap_ok = 1'b0; obs_error = 1'bx; obs_mask = 'x;
    while (!done_seen && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (start_tx !== '0) begin
        if ($countones(start_tx) != 1) onehot_err++;
        for (int i = 0; i < N; i++)
          if (start_tx[i] === 1'b1) begin
            obs_mod.push_back(i); obs_cyc.push_back(cyc);
            if (tx_data !== codes[i]) txdata_err++;
          end
      end
      if (shoot === 1'b1) shoot_cycles++;
      if (frame_done === 1'b1) begin
        done_seen = 1'b1; obs_error = frame_error; obs_mask = fail_mask;
        fall_gap_ok = (p2 === 1'b1 && p1 === 1'b0);
      end
      p2 = p1; p1 = shoot;
      if (busy_hold > 0 && cyc == busy_hold) tx_busy[0] = 1'b0;
      frame_valid = (junk && !done_seen) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (junk) for (int i = 0; i < N; i++) frame_data[i*8 +: 8] = 8'($urandom);
    end
    frame_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; frame_valid = 1'b0; tx_busy = '0; frame_data = '0;
    repeat (3) @(negedge clk);
    total++; if (frame_ready !== 1'b0) $display("FAIL reset_ready got %b want 0", frame_ready); else passed++;
    total++; if (start_tx !== '0) $display("FAIL reset_start_tx got %h want 0", start_tx); else passed++;
    total++; if (tx_data !== 8'h00) $display("FAIL reset_tx_data got %h want 00", tx_data); else passed++;
    total++; if (shoot !== 1'b0) $display("FAIL reset_shoot got %b want 0", shoot); else passed++;
    total++; if ({frame_done, frame_error} !== 2'b00) $display("FAIL reset_done_err got %b want 00", {frame_done, frame_error}); else passed++;
    total++; if (fail_mask !== '0) $display("FAIL reset_fail_mask got %h want 0", fail_mask); else passed++;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (frame_ready !== 1'b1) $display("FAIL reset_release_ready got %b want 1", frame_ready); else passed++;
  endtask

  task automatic test_all_ack();
    seq_codes(); plan_all_ack(20); build_expect();
    run_frame(0, 1'b0);
    total++; if (!done_seen) $display("FAIL all_ack_done got none want frame_done"); else passed++;
    total++; if (!seq_match()) $display("FAIL all_ack_order got %0d pulses want %0d in order", obs_mod.size(), exp_mod.size()); else passed++;
    total++; if (shoot_cycles != SW) $display("FAIL all_ack_shoot_len got %0d want %0d", shoot_cycles, SW); else passed++;
    total++; if (!fall_gap_ok) $display("FAIL all_ack_done_timing got misplaced want one cycle after shoot falls"); else passed++;
    total++; if (obs_error !== 1'b0) $display("FAIL all_ack_error got %b want 0", obs_error); else passed++;
    total++; if (obs_mask !== '0) $display("FAIL all_ack_mask got %h want 0", obs_mask); else passed++;
    total++; if (!ready_fell) $display("FAIL all_ack_ready_fall got 1 want 0 after accept"); else passed++;
    total++; if (onehot_err + txdata_err != 0) $display("FAIL all_ack_tx got %0d/%0d bad pulses want 0", onehot_err, txdata_err); else passed++;
  endtask

  task automatic test_silent_module();
    int last = -1;
    bit sp_ok = 1'b1;
    seq_codes(); plan_all_ack(20);
    for (int a = 0; a <= R; a++) kind[4][a] = K_SIL;
    build_expect();
    run_frame(0, 1'b0);
    foreach (obs_mod[k]) if (obs_mod[k] == 4) begin
      if (last >= 0 && obs_cyc[k] - last < T) sp_ok = 1'b0;
      last = obs_cyc[k];
    end
    total++; if (!done_seen) $display("FAIL silent_done got none want frame_done"); else passed++;
    total++; if (count_pulses(4) != 3) $display("FAIL silent_pulses got %0d want 3", count_pulses(4)); else passed++;
    total++; if (!sp_ok) $display("FAIL silent_spacing got under %0d cycles want at least %0d", T, T); else passed++;
    total++; if (obs_mask !== 9'h010) $display("FAIL silent_mask got %h want 010", obs_mask); else passed++;
    total++; if (shoot_cycles != 0) $display("FAIL silent_shoot got %0d want 0", shoot_cycles); else passed++;
    total++; if (obs_error !== 1'b1) $display("FAIL silent_error got %b want 1", obs_error); else passed++;
    total++; if (!seq_match()) $display("FAIL silent_order got %0d pulses want %0d", obs_mod.size(), exp_mod.size()); else passed++;
  endtask

  task automatic test_parity_retry();
    seq_codes(); plan_all_ack(20);
    kind[2][0] = K_PAR;
    build_expect();
    run_frame(0, 1'b0);
    total++; if (count_pulses(2) != 2) $display("FAIL parity_pulses got %0d want 2", count_pulses(2)); else passed++;
    total++; if (shoot_cycles != SW) $display("FAIL parity_shoot got %0d want %0d", shoot_cycles, SW); else passed++;
    total++; if (obs_mask !== '0) $display("FAIL parity_mask got %h want 0", obs_mask); else passed++;
    total++; if (obs_error !== 1'b0) $display("FAIL parity_error got %b want 0", obs_error); else passed++;
  endtask

  task automatic test_tx_busy();
    int hold = 2 * T;
    seq_codes(); plan_all_ack(20); build_expect();
    run_frame(hold, 1'b0);
    total++; if (obs_cyc.size() == 0 || obs_mod[0] != 0 || obs_cyc[0] != hold + 1)
      $display("FAIL busy_first_start got cycle %0d want %0d", (obs_cyc.size() != 0) ? obs_cyc[0] : -1, hold + 1);
    else passed++;
    total++; if (count_pulses(0) != 1) $display("FAIL busy_pulses got %0d want 1", count_pulses(0)); else passed++;
    total++; if (shoot_cycles != SW) $display("FAIL busy_shoot got %0d want %0d", shoot_cycles, SW); else passed++;
  endtask

  task automatic test_random();
    int r;
    noise_en = 1'b1;
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < N; i++) begin
        codes[i] = 8'($urandom);
        for (int a = 0; a <= R; a++) begin
          r = $urandom_range(0, 9);
          case (r)
            0:       begin kind[i][a] = K_PAR; dly[i][a] = $urandom_range(1, 30); end
            1:       begin kind[i][a] = K_DAT; dly[i][a] = $urandom_range(1, 30); end
            2:       begin kind[i][a] = K_SIL; dly[i][a] = 0; end
            3:       begin kind[i][a] = K_ACK; dly[i][a] = 0; end
            4:       begin kind[i][a] = K_ACK; dly[i][a] = T - 1; end
            default: begin kind[i][a] = K_ACK; dly[i][a] = $urandom_range(1, 30); end
          endcase
        end
      end
      build_expect();
      run_frame(0, 1'b1);
      total++; if (!done_seen) $display("FAIL rand%0d_done got none want frame_done", f); else passed++;
      total++; if (!seq_match()) $display("FAIL rand%0d_order got %0d pulses want %0d", f, obs_mod.size(), exp_mod.size()); else passed++;
      total++; if (obs_mask !== exp_mask) $display("FAIL rand%0d_mask got %h want %h", f, obs_mask, exp_mask); else passed++;
      total++; if (obs_error !== (|exp_mask)) $display("FAIL rand%0d_error got %b want %b", f, obs_error, |exp_mask); else passed++;
      total++; if (shoot_cycles != ((exp_mask == '0) ? SW : 0)) $display("FAIL rand%0d_shoot got %0d want %0d", f, shoot_cycles, (exp_mask == '0) ? SW : 0); else passed++;
      total++; if (onehot_err + txdata_err != 0) $display("FAIL rand%0d_tx got %0d/%0d bad pulses want 0", f, onehot_err, txdata_err); else passed++;
    end
    noise_en = 1'b0;
  endtask

`ifdef UART_SCHED_SKIP_IDLE_EN
  task automatic test_skip();
    seq_codes(); codes[1] = 8'h00; codes[7] = 8'h00;
    plan_all_ack(20); build_expect();
    run_frame(0, 1'b0);
    total++; if (obs_mod.size() != 7) $display("FAIL skip_pulses got %0d want 7", obs_mod.size()); else passed++;
    total++; if (count_pulses(1) + count_pulses(7) != 0) $display("FAIL skip_idle_pulses got %0d want 0", count_pulses(1) + count_pulses(7)); else passed++;
    total++; if (shoot_cycles != SW) $display("FAIL skip_shoot got %0d want %0d", shoot_cycles, SW); else passed++;
    total++; if (obs_mask !== '0) $display("FAIL skip_mask got %h want 0", obs_mask); else passed++;
  endtask
`endif

  task automatic test_reset_mid_shoot();
    int w = 0, dn = 0, sh = 0;
    for (int i = 0; i < N; i++) codes[i] = 8'($urandom_range(1, 255));
    plan_all_ack(3);
    offer_frame(0);
    while (shoot !== 1'b1 && w < 2000) begin @(negedge clk); w++; end
    total++; if (shoot !== 1'b1) $display("FAIL midreset_reach_shoot got %b want 1", shoot); else passed++;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    total++; if (shoot !== 1'b0) $display("FAIL midreset_shoot got %b want 0", shoot); else passed++;
    total++; if (frame_ready !== 1'b0) $display("FAIL midreset_ready got %b want 0", frame_ready); else passed++;
    total++; if (frame_done !== 1'b0) $display("FAIL midreset_done got %b want 0", frame_done); else passed++;
    reset = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (frame_done === 1'b1) dn++;
      if (shoot === 1'b1) sh++;
    end
    total++; if (dn + sh != 0) $display("FAIL midreset_after got %0d done/%0d shoot cycles want 0", dn, sh); else passed++;
    total++; if (frame_ready !== 1'b1) $display("FAIL midreset_ready_after got %b want 1", frame_ready); else passed++;
  endtask

  initial begin
    reset = 1'b1; frame_valid = 1'b0; frame_data = '0; tx_busy = '0;
    test_reset();
    test_all_ack();
    test_silent_module();
    test_parity_retry();
    test_tx_busy();
    test_random();
`ifdef UART_SCHED_SKIP_IDLE_EN
    test_skip();
`endif
    test_reset_mid_shoot();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got no completion want finish before 100000 cycles");
    $fatal(1, "watchdog");
  end

endmodule
